// File: rtl/adder_tree_feeder_pkg.sv
// Shared types and sizing helpers for the adder-tree operand feeder.
package adder_tree_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } buf_state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  localparam int DEF_NUM_INPUTS = 36;
  localparam int DEF_LANES      = 4;
  localparam int BEATS          = ceil_div(DEF_NUM_INPUTS, DEF_LANES);

endpackage

// File: rtl/adder_tree_feeder_valid_delay_line.sv
// Fixed-depth valid shift register with synchronous active-low clear.
module valid_delay_line #(
  parameter int DEPTH = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] vld_pipe;

  always_ff @(posedge clk) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= (vld_pipe << 1) | DEPTH'(din);
  end

  assign dout = vld_pipe[DEPTH-1];

endmodule

// File: rtl/adder_tree_feeder.sv
// Ping-pong gatherer: packs LANES-wide beats into a NUM_INPUTS operand vector
// for adder_tree and strobes sum_valid when the tree output is ready.
module adder_tree_feeder
  import adder_tree_pkg::*;
#(
  parameter int NUM_INPUTS   = 36,
  parameter int INPUT_WIDTH  = 32,
  parameter int LANES        = 4,
  parameter int TREE_LATENCY = $clog2(NUM_INPUTS)
) (
  input  logic                                   clk,
  input  logic                                   arst_n_in,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [LANES-1:0][INPUT_WIDTH-1:0]      in_data,
  input  logic                                   in_last,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [NUM_INPUTS-1:0][INPUT_WIDTH-1:0] out_vec,
  output logic                                   sum_valid
);

  localparam int NBEATS = ceil_div(NUM_INPUTS, LANES);
  localparam int CW     = $clog2(NBEATS) + 1;

  typedef logic [NUM_INPUTS-1:0][INPUT_WIDTH-1:0] vec_t;

  buf_state_e    st_q [2];
  buf_state_e    st_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] beat_q, beat_d;
  vec_t          buf_q [2];
  vec_t          hold_q;
  logic          beat_acc, vec_done, launch;

  assign in_ready  = (st_q[wr_ptr_q] != FULL);
  assign out_valid = (st_q[rd_ptr_q] == FULL);
  assign beat_acc  = in_valid && in_ready;
  assign vec_done  = beat_acc && (in_last || (beat_q == CW'(NBEATS - 1)));
  assign launch    = out_valid && out_ready;

  // The tree samples continuously, so keep showing the last launched vector
  // until the next one is complete rather than exposing a half-filled buffer.
  assign out_vec = out_valid ? buf_q[rd_ptr_q] : hold_q;

  always_comb begin
    st_d     = st_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    beat_d   = beat_q;
    if (beat_acc) begin
      if (vec_done) begin
        st_d[wr_ptr_q] = FULL;
        wr_ptr_d       = ~wr_ptr_q;
        beat_d         = '0;
      end else begin
        st_d[wr_ptr_q] = FILLING;
        beat_d         = beat_q + 1'b1;
      end
    end
    // Write and read buffers always differ here, so both updates can apply.
    if (launch) begin
      st_d[rd_ptr_q] = EMPTY;
      rd_ptr_d       = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n_in) begin
      st_q     <= '{EMPTY, EMPTY};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      beat_q   <= '0;
    end else begin
      st_q     <= st_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      beat_q   <= beat_d;
    end
  end

  // Element i belongs to beat i/LANES, lane i%LANES; lanes past the vector end
  // have no element and are simply never written.
  always_ff @(posedge clk) begin
    if (!arst_n_in) begin
      buf_q  <= '{default: '0};
      hold_q <= '0;
    end else begin
      if (launch) hold_q <= buf_q[rd_ptr_q];
      if (beat_acc) begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
          if (int'(beat_q) == i / LANES)
            buf_q[wr_ptr_q][i] <= in_data[i % LANES];
          else if (in_last && (int'(beat_q) < i / LANES))
            buf_q[wr_ptr_q][i] <= '0;
        end
      end
    end
  end

  valid_delay_line #(.DEPTH(TREE_LATENCY)) u_sum_dly (
    .clk   (clk),
    .rst_n (arst_n_in),
    .din   (launch),
    .dout  (sum_valid)
  );

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Scoreboard bench for adder_tree_feeder: directed vectors, monitor checks launches and sum_valid timing.
module tb_adder_tree_feeder;
  import adder_tree_pkg::*;

  localparam int N  = 36;
  localparam int W  = 32;
  localparam int L  = 4;
  localparam int TL = $clog2(N);
  localparam int NB = ceil_div(N, L);
  localparam int L5 = 5;
  localparam int NB5 = ceil_div(N, L5);

  typedef logic [N-1:0][W-1:0]  vec_t;
  typedef logic [L-1:0][W-1:0]  beat_t;
  typedef logic [L5-1:0][W-1:0] beat5_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  beat_t  in_data = '0;
  logic   in_ready, out_valid, sum_valid;
  vec_t   out_vec;

  logic   in_valid5 = 1'b0, in_last5 = 1'b0, out_ready5 = 1'b1;
  beat5_t in_data5 = '0;
  logic   in_ready5, out_valid5, sum_valid5;
  vec_t   out_vec5;

  adder_tree_feeder #(.NUM_INPUTS(N), .INPUT_WIDTH(W), .LANES(L)) u_dut (
    .clk(clk), .arst_n_in(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_vec(out_vec), .sum_valid(sum_valid));

  adder_tree_feeder #(.NUM_INPUTS(N), .INPUT_WIDTH(W), .LANES(L5)) u_dut5 (
    .clk(clk), .arst_n_in(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
    .in_data(in_data5), .in_last(in_last5), .out_valid(out_valid5),
    .out_ready(out_ready5), .out_vec(out_vec5), .sum_valid(sum_valid5));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   errors = 0, checks = 0;
  vec_t exp_q[$];
  int   sum_q[$];
  int   sv_log[$];
  vec_t last_vec = '0;
  vec_t act_last = '0;

  function automatic int first_diff(input vec_t a, input vec_t b);
    for (int i = 0; i < N; i++) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  task automatic check1(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected vectors on launch, tracks sum_valid deadlines.
  always @(negedge clk) begin
    vec_t e;
    int   d;
    if (sum_valid === 1'b1) begin
      sv_log.push_back(cyc);
      checks++;
      if (sum_q.size() == 0 || sum_q[0] != cyc) begin
        errors++;
        $display("FAIL sum_valid: pulse at cycle %0d, next expected %0d", cyc,
                 (sum_q.size() == 0) ? -1 : sum_q[0]);
      end else sum_q.pop_front();
    end else if (sum_q.size() > 0 && sum_q[0] == cyc) begin
      checks++; errors++;
      $display("FAIL sum_valid: missing pulse at cycle %0d, got %b want 1", cyc, sum_valid);
      void'(sum_q.pop_front());
    end
    if (!rst_n) begin
      sum_q.delete();
      exp_q.delete();
      last_vec = '0;
    end else if (out_valid && out_ready) begin
      checks++;
      act_last = out_vec;
      sum_q.push_back(cyc + TL);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL launch: unexpected vector at cycle %0d, got elem0 %0d want none", cyc, out_vec[0]);
      end else begin
        e = exp_q.pop_front();
        d = first_diff(out_vec, e);
        if (d >= 0) begin
          errors++;
          $display("FAIL out_vec: cycle %0d idx %0d got %0d want %0d", cyc, d,
                   $signed(out_vec[d]), $signed(e[d]));
        end
        last_vec = e;
      end
    end else if (out_valid === 1'b0) begin
      checks++;
      d = first_diff(out_vec, last_vec);
      if (d >= 0) begin
        errors++;
        $display("FAIL out_vec_hold: cycle %0d idx %0d got %0d want %0d", cyc, d,
                 $signed(out_vec[d]), $signed(last_vec[d]));
      end
    end
  end

  task automatic send_beat(input beat_t d, input bit last, output int stalls);
    stalls = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    @(negedge clk);
    while (in_ready !== 1'b1) begin
      stalls++;
      if (stalls > 200) begin
        checks++; errors++;
        $display("FAIL beat_accept: in_ready got %b want 1 within 200 cycles", in_ready);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Vector element i carries base+i; unsent elements of a short vector expect 0.
  task automatic send_vec(input int base, input int nb, input bit last, output int stalls);
    vec_t  e;
    beat_t d;
    int    s;
    for (int i = 0; i < N; i++) e[i] = (i < nb * L) ? W'(base + i) : '0;
    exp_q.push_back(e);
    stalls = 0;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < L; k++) d[k] = W'(base + b * L + k);
      send_beat(d, last && (b == nb - 1), s);
      stalls += s;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || sum_q.size() != 0) && n < 100) begin
      n++;
      @(negedge clk);
    end
    check1("drain_timeout", (exp_q.size() == 0 && sum_q.size() == 0) ? 1 : 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int    s, st, n0, sum, mn, mx, k;
    vec_t  v1, e5;
    beat_t d;

    // reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check1("rst_out_valid", out_valid, 0);
    check1("rst_in_ready", in_ready, 1);
    check1("rst_sum_valid", sum_valid, 0);
    check1("rst_out_vec_diff", first_diff(out_vec, '0), -1);
    @(posedge clk); #1;

    // 1: full vector 1..36, sum 666
    out_ready = 1'b1;
    send_vec(1, NB, 1'b0, s);
    @(negedge clk);
    check1("t1_out_valid_latency", out_valid, 1);
    @(posedge clk); #1;
    wait_drain();
    sum = 0;
    for (int i = 0; i < N; i++) sum += $signed(act_last[i]);
    check1("t1_tree_sum", sum, 666);

    // 2: full vector, then in_last on beat 2 zero-fills a stale buffer, then counter restart
    send_vec(1000, NB, 1'b0, s);
    send_vec(1, 3, 1'b1, s);
    send_vec(2000, NB, 1'b0, s);
    wait_drain();

    // 3: backpressure, two vectors fill both buffers, third stalls
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) v1[i] = W'(3000 + i);
    send_vec(3000, NB, 1'b0, s);
    send_vec(3100, NB, 1'b0, s);
    @(negedge clk);
    check1("t3_in_ready_full", in_ready, 0);
    @(posedge clk); #1;
    fork
      send_vec(3200, NB, 1'b0, st);
      begin
        repeat (4) @(negedge clk);
        check1("t3_stall_in_ready", in_ready, 0);
        check1("t3_stall_out_valid", out_valid, 1);
        check1("t3_stall_out_vec_diff", first_diff(out_vec, v1), -1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    check1("t3_stalled_beats_min", (st > 0) ? 1 : 0, 1);
    wait_drain();

    // 4: ten streamed vectors, no stalls, sum_valid every NB cycles
    n0 = sv_log.size();
    st = 0;
    for (int v = 0; v < 10; v++) begin
      send_vec(10000 + v * 100, NB, 1'b0, s);
      st += s;
    end
    wait_drain();
    check1("t4_stalls", st, 0);
    check1("t4_pulses", sv_log.size() - n0, 10);
    mn = 1000; mx = 0;
    for (int j = n0 + 1; j < sv_log.size(); j++) begin
      if (sv_log[j] - sv_log[j-1] < mn) mn = sv_log[j] - sv_log[j-1];
      if (sv_log[j] - sv_log[j-1] > mx) mx = sv_log[j] - sv_log[j-1];
    end
    check1("t4_spacing_min", mn, NB);
    check1("t4_spacing_max", mx, NB);

    // 5: reset mid-vector with two launches in flight
    out_ready = 1'b0;
    send_vec(20000, NB, 1'b0, s);
    send_vec(21000, NB, 1'b0, s);
    fork
      for (int b = 0; b < 5; b++) begin
        for (int k2 = 0; k2 < L; k2++) d[k2] = W'(7777 + b * L + k2);
        send_beat(d, 1'b0, s);
      end
      out_ready = 1'b1;
    join
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < TL; c++) begin
      @(negedge clk);
      check1("t5_sum_after_reset", sum_valid, 0);
      if (c == 0) begin
        check1("t5_out_valid_after_reset", out_valid, 0);
        check1("t5_in_ready_after_reset", in_ready, 1);
      end
    end
    @(posedge clk); #1;
    send_vec(22000, NB, 1'b0, s);
    wait_drain();

    // 6: LANES=5 instance, beat 7 lanes 1..4 dropped
    for (int b = 0; b < NB5; b++) begin
      in_valid5 = 1'b1;
      for (int k2 = 0; k2 < L5; k2++) in_data5[k2] = W'(100 * b + k2 + 1);
      @(negedge clk);
      check1("t6_in_ready", in_ready5, 1);
      @(posedge clk); #1;
    end
    in_valid5 = 1'b0;
    for (int i = 0; i < N; i++) e5[i] = W'(100 * (i / L5) + (i % L5) + 1);
    @(negedge clk);
    check1("t6_out_valid", out_valid5, 1);
    check1("t6_out_vec_diff", first_diff(out_vec5, e5), -1);
    check1("t6_elem35", out_vec5[35], 701);
    k = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (sum_valid5 === 1'b1 && k < 0) k = c;
    end
    check1("t6_sum_latency", k, TL);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run got past 500000 time units want finish earlier");
    $fatal(1, "watchdog");
  end

endmodule
